// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match-level control logic.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SERVE,
    RALLY,
    POINT_PAUSE,
    GAME_OVER
  } match_state_t;

  localparam int                 SCORE_W           = 4;
  localparam logic [SCORE_W-1:0] WIN_SCORE_DEFAULT = 4'd9;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter: ticks on end_of_frame, stops at zero, done while zero.
module frame_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk65MHz,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;

  // A load wins over a coincident tick so the full interval is always counted.
  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/match_control.sv
// Match sequencer for the pong ball FSM: serve, scoring, pauses, server choice, game over.
// Optional build macro AUTO_SERVE_EN: serve automatically after AUTO_SERVE_FRAMES in WAIT_SERVE.
//
// state       | meaning
// IDLE        | menu shown, waiting for a game screen
// WAIT_SERVE  | ball parked, waiting for the serve
// RALLY       | ball in play, watching ball-out pulses
// POINT_PAUSE | point scored, holding PAUSE_FRAMES frames
// GAME_OVER   | a player reached WIN_SCORE, scores frozen
module match_control
  import pong_pkg::*;
#(
  parameter logic [SCORE_W-1:0] WIN_SCORE         = WIN_SCORE_DEFAULT,
  parameter int                 PAUSE_FRAMES      = 60,
  parameter int                 AUTO_SERVE_FRAMES = 120
) (
  input  logic               clk65MHz,
  input  logic               rst,
  input  logic               end_of_frame,
  input  logic               screen_idle,
  input  logic               screen_single,
  input  logic               screen_multi,
  input  logic               serve_btn,
  input  logic               ball_out_p1,
  input  logic               ball_out_p2,
  output logic               serve,
  output logic               server,
  output logic [SCORE_W-1:0] points_player_1,
  output logic [SCORE_W-1:0] points_player_2,
  output logic               rally_active,
  output logic               game_over,
  output logic               winner
);

  localparam int CNT_W = $clog2(max_int(PAUSE_FRAMES, AUTO_SERVE_FRAMES) + 1);

  match_state_t       state_q, state_d;
  logic               btn_prev_q;
  logic               btn_rise;
  logic               serve_q, serve_d;
  logic               server_q, server_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic               winner_q, winner_d;
  logic               rally_q, over_q;
  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tmr_done;
  logic               auto_fire;

  assign btn_rise = serve_btn & ~btn_prev_q;

`ifdef AUTO_SERVE_EN
  assign auto_fire = tmr_done;
`else
  assign auto_fire = 1'b0;
`endif

  frame_timer #(
    .CNT_W(CNT_W)
  ) u_frame_timer (
    .clk65MHz  (clk65MHz),
    .rst       (rst),
    .tick_i    (end_of_frame),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    serve_d  = 1'b0;
    server_d = server_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    tmr_load = 1'b0;
    tmr_val  = CNT_W'(PAUSE_FRAMES);

    if (screen_idle) begin
      state_d  = IDLE;
      p1_d     = '0;
      p2_d     = '0;
      server_d = 1'b0;
      winner_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (screen_single || screen_multi) state_d = WAIT_SERVE;
        end
        WAIT_SERVE: begin
          if (btn_rise || auto_fire) begin
            serve_d = 1'b1;
            state_d = RALLY;
          end
        end
        RALLY: begin
          if (ball_out_p1 && ball_out_p2) begin
            state_d  = POINT_PAUSE;
            tmr_load = 1'b1;
          end else if (ball_out_p1) begin
            server_d = 1'b0;
            if (p2_q < WIN_SCORE) p2_d = p2_q + 1'b1;
            if (p2_d == WIN_SCORE) begin
              state_d  = GAME_OVER;
              winner_d = 1'b1;
            end else begin
              state_d  = POINT_PAUSE;
              tmr_load = 1'b1;
            end
          end else if (ball_out_p2) begin
            server_d = 1'b1;
            if (p1_q < WIN_SCORE) p1_d = p1_q + 1'b1;
            if (p1_d == WIN_SCORE) begin
              state_d  = GAME_OVER;
              winner_d = 1'b0;
            end else begin
              state_d  = POINT_PAUSE;
              tmr_load = 1'b1;
            end
          end
        end
        POINT_PAUSE: begin
          if (tmr_done) state_d = WAIT_SERVE;
        end
        GAME_OVER: begin
          if (btn_rise) begin
            p1_d     = '0;
            p2_d     = '0;
            server_d = 1'b0;
            state_d  = WAIT_SERVE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Against the AI the human always serves.
    if (screen_single) server_d = 1'b0;

`ifdef AUTO_SERVE_EN
    if ((state_d == WAIT_SERVE) && (state_q != WAIT_SERVE)) begin
      tmr_load = 1'b1;
      tmr_val  = CNT_W'(AUTO_SERVE_FRAMES);
    end
`endif
  end

  // btn_prev resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk65MHz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      btn_prev_q <= 1'b1;
      serve_q    <= 1'b0;
      server_q   <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
      winner_q   <= 1'b0;
      rally_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= serve_btn;
      serve_q    <= serve_d;
      server_q   <= server_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      winner_q   <= winner_d;
      rally_q    <= (state_d == RALLY);
      over_q     <= (state_d == GAME_OVER);
    end
  end

  assign serve           = serve_q;
  assign server          = server_q;
  assign points_player_1 = p1_q;
  assign points_player_2 = p2_q;
  assign rally_active    = rally_q;
  assign game_over       = over_q;
  assign winner          = winner_q;

endmodule

// File: tb/tb_match_control.sv
// Bench for match_control: vector table, hand-written corner sequences, random run against a model.
module tb_match_control;

  localparam logic [3:0] WIN     = 4'd3;
  localparam int         PAUSE_N = 2;
  localparam int         AUTO_N  = 3;

  logic       clk65MHz = 1'b0;
  logic       rst = 1'b1;
  logic       end_of_frame = 1'b0, screen_idle = 1'b0, screen_single = 1'b0, screen_multi = 1'b0;
  logic       serve_btn = 1'b0, ball_out_p1 = 1'b0, ball_out_p2 = 1'b0;
  logic       serve, server, rally_active, game_over, winner;
  logic [3:0] points_player_1, points_player_2;

  int checks = 0;
  int errors = 0;

  always #5 clk65MHz = ~clk65MHz;

  match_control #(
    .WIN_SCORE        (WIN),
    .PAUSE_FRAMES     (PAUSE_N),
    .AUTO_SERVE_FRAMES(AUTO_N)
  ) dut (
    .clk65MHz       (clk65MHz),
    .rst            (rst),
    .end_of_frame   (end_of_frame),
    .screen_idle    (screen_idle),
    .screen_single  (screen_single),
    .screen_multi   (screen_multi),
    .serve_btn      (serve_btn),
    .ball_out_p1    (ball_out_p1),
    .ball_out_p2    (ball_out_p2),
    .serve          (serve),
    .server         (server),
    .points_player_1(points_player_1),
    .points_player_2(points_player_2),
    .rally_active   (rally_active),
    .game_over      (game_over),
    .winner         (winner)
  );

  typedef struct packed {logic idle, single, multi, btn, bo1, bo2, eof;} in_t;
  typedef struct packed {logic serve, server, rally, over, win; logic [3:0] p1, p2;} out_t;
  typedef struct {in_t in; out_t exp;} vec_t;

  // ---------------- reference model: game rules in plain terms ----------------
  localparam int PH_MENU = 0, PH_READY = 1, PH_PLAY = 2, PH_PAUSE = 3, PH_OVER = 4;
  int   m_phase;
  int   m_pts[2];
  int   m_frames;
  logic m_serve, m_server, m_winner, m_btn_last;

  function automatic void model_reset();
    m_phase = PH_MENU; m_pts[0] = 0; m_pts[1] = 0; m_frames = 0;
    m_serve = 0; m_server = 0; m_winner = 0; m_btn_last = 1;
  endfunction

  function automatic void model_step();
    logic rise;
    int   who;
    rise       = serve_btn && !m_btn_last;
    m_btn_last = serve_btn;
    m_serve    = 0;
    if (screen_idle) begin
      m_phase = PH_MENU; m_pts[0] = 0; m_pts[1] = 0; m_server = 0; m_winner = 0;
    end else if (m_phase == PH_MENU) begin
      if (screen_single || screen_multi) begin m_phase = PH_READY; m_frames = 0; end
    end else if (m_phase == PH_READY) begin
      logic auto_go;
      auto_go = 0;
`ifdef AUTO_SERVE_EN
      auto_go = (m_frames == AUTO_N);
`endif
      if (rise || auto_go) begin m_serve = 1; m_phase = PH_PLAY; end
      else if (end_of_frame) m_frames++;
    end else if (m_phase == PH_PLAY) begin
      if (ball_out_p1 && ball_out_p2) begin
        m_phase = PH_PAUSE; m_frames = 0;
      end else if (ball_out_p1 || ball_out_p2) begin
        who = ball_out_p2 ? 0 : 1;
        if (m_pts[who] < int'(WIN)) m_pts[who]++;
        m_server = ball_out_p2;
        if (m_pts[who] == int'(WIN)) begin m_phase = PH_OVER; m_winner = (who == 1); end
        else begin m_phase = PH_PAUSE; m_frames = 0; end
      end
    end else if (m_phase == PH_PAUSE) begin
      if (m_frames == PAUSE_N) begin m_phase = PH_READY; m_frames = 0; end
      else if (end_of_frame) m_frames++;
    end else if (m_phase == PH_OVER) begin
      if (rise) begin m_pts[0] = 0; m_pts[1] = 0; m_server = 0; m_phase = PH_READY; m_frames = 0; end
    end
    if (screen_single) m_server = 0;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.serve = m_serve; o.server = m_server; o.rally = (m_phase == PH_PLAY);
    o.over = (m_phase == PH_OVER); o.win = m_winner;
    o.p1 = 4'(m_pts[0]); o.p2 = 4'(m_pts[1]);
    return o;
  endfunction

  // ---------------- helpers ----------------
  function automatic out_t dut_out();
    return {serve, server, rally_active, game_over, winner, points_player_1, points_player_2};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic idle_v, btn_v, bo1_v, bo2_v, eof_v);
    screen_idle = idle_v; serve_btn = btn_v; ball_out_p1 = bo1_v; ball_out_p2 = bo2_v;
    end_of_frame = eof_v;
    @(posedge clk65MHz);
    model_step();
    #1;
  endtask

  task automatic do_reset(input logic btn_v);
    rst = 1'b1;
    screen_idle = 0; screen_single = 0; screen_multi = 0; serve_btn = btn_v;
    ball_out_p1 = 0; ball_out_p2 = 0; end_of_frame = 0;
    model_reset();
    repeat (2) @(posedge clk65MHz);
    #1 rst = 1'b0;
  endtask

  task automatic press(input string nm);
    step(0, 1, 0, 0, 0);
    check(nm, 16'(serve), 16'd1);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic pause_out();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
  endtask

  function automatic vec_t mk(input in_t i, input logic s, sv, r, o, w, input logic [3:0] a, b);
    vec_t v;
    v.in = i; v.exp = {s, sv, r, o, w, a, b};
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    // inputs: idle single multi btn bo1 bo2 eof
    tbl[0] = mk(7'b0010000, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    tbl[1] = mk(7'b0011000, 1, 0, 1, 0, 0, 4'd0, 4'd0);
    tbl[2] = mk(7'b0011000, 0, 0, 1, 0, 0, 4'd0, 4'd0);
    tbl[3] = mk(7'b0010010, 0, 1, 0, 0, 0, 4'd1, 4'd0);
    tbl[4] = mk(7'b0010001, 0, 1, 0, 0, 0, 4'd1, 4'd0);
    tbl[5] = mk(7'b0011000, 0, 1, 0, 0, 0, 4'd1, 4'd0);
    tbl[6] = mk(7'b0010001, 0, 1, 0, 0, 0, 4'd1, 4'd0);
    tbl[7] = mk(7'b0010000, 0, 1, 0, 0, 0, 4'd1, 4'd0);
    tbl[8] = mk(7'b0011000, 1, 1, 1, 0, 0, 4'd1, 4'd0);
    tbl[9] = mk(7'b0010100, 0, 0, 0, 0, 0, 4'd1, 4'd1);

    // reset values and the basic serve/point/pause flow
    do_reset(0);
    check("reset_outputs", 16'(dut_out()), 16'd0);
    for (int i = 0; i < 10; i++) begin
      screen_single = tbl[i].in.single;
      screen_multi  = tbl[i].in.multi;
      step(tbl[i].in.idle, tbl[i].in.btn, tbl[i].in.bo1, tbl[i].in.bo2, tbl[i].in.eof);
      check($sformatf("table_row%0d", i), 16'(dut_out()), 16'(tbl[i].exp));
    end

    // player 1 wins, then a press restarts the match
    do_reset(0);
    screen_multi = 1;
    step(0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      press($sformatf("win_serve%0d", k));
      step(0, 0, 0, 1, 0);
      check($sformatf("win_p1_%0d", k), 16'(points_player_1), 16'(k));
      if (k < 3) pause_out();
    end
    check("win_over", 16'({game_over, winner, rally_active, server}), 16'b1001);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    check("win_hold", 16'({game_over, points_player_1, points_player_2}), 16'h130);
    step(0, 1, 0, 0, 0);
    check("win_clear", 16'({game_over, server, points_player_1, points_player_2}), 16'h000);
    step(0, 0, 0, 0, 0);
    press("win_restart_serve");

    // simultaneous ball-out, then pulses ignored during the pause
    do_reset(0);
    screen_multi = 1;
    step(0, 0, 0, 0, 0);
    press("both_serve");
    step(0, 0, 1, 1, 0);
    check("both_no_score", 16'({rally_active, server, points_player_1, points_player_2}), 16'h000);
    step(0, 0, 0, 1, 1);
    check("pause_ignore_bo2", 16'(points_player_1), 16'd0);
    step(0, 0, 1, 0, 1);
    check("pause_ignore_bo1", 16'(points_player_2), 16'd0);
    step(0, 0, 0, 0, 0);
    press("both_pause_done");

    // idle screen mid-rally at 2:1
    do_reset(0);
    screen_multi = 1;
    step(0, 0, 0, 0, 0);
    press("idle_s1"); step(0, 0, 0, 1, 0); pause_out();
    press("idle_s2"); step(0, 0, 0, 1, 0); pause_out();
    press("idle_s3"); step(0, 0, 1, 0, 0); pause_out();
    press("idle_s4");
    check("idle_pre_score", 16'({points_player_1, points_player_2}), 16'h21);
    step(1, 0, 0, 0, 0);
    check("idle_clear", 16'(dut_out()), 16'd0);
    screen_multi = 0;
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("idle_no_serve", 16'(serve), 16'd0);

    // asynchronous reset in the middle of a pause
    do_reset(0);
    screen_multi = 1;
    step(0, 0, 0, 0, 0);
    press("arst_serve");
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    check("arst_pre", 16'({server, points_player_1}), 16'h11);
    #3 rst = 1'b1;
    model_reset();
    #1 check("arst_now", 16'(dut_out()), 16'd0);
    repeat (2) @(posedge clk65MHz);
    #1 rst = 1'b0;

    // button held through reset must not serve
    do_reset(1);
    screen_multi = 1;
    step(0, 1, 0, 0, 0);
    check("held_no_serve1", 16'(serve), 16'd0);
    step(0, 1, 0, 0, 0);
    check("held_no_serve2", 16'(serve), 16'd0);
    step(0, 0, 0, 0, 0);
    press("held_release_serve");

    // single mode: server stays 0 even when player 2 loses a point
    do_reset(0);
    screen_single = 1;
    step(0, 0, 0, 0, 0);
    press("single_serve");
    step(0, 0, 0, 1, 0);
    check("single_server", 16'({server, points_player_1}), 16'h01);

`ifdef AUTO_SERVE_EN
    do_reset(0);
    screen_multi = 1;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < AUTO_N; i++) begin
      step(0, 0, 0, 0, 1);
      check($sformatf("auto_wait%0d", i), 16'(serve), 16'd0);
    end
    step(0, 0, 0, 0, 0);
    check("auto_serve", 16'({serve, rally_active}), 16'b11);
`endif

    // randomized play against the model
    do_reset(0);
    screen_multi = 1;
    begin
      logic btn_l;
      btn_l = 0;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 299) == 0) begin
          case ($urandom_range(0, 2))
            0: begin screen_single = 1; screen_multi = 0; end
            1: begin screen_single = 0; screen_multi = 1; end
            default: begin screen_single = 0; screen_multi = 0; end
          endcase
        end
        if ($urandom_range(0, 4) == 0) btn_l = ~btn_l;
        step(($urandom_range(0, 149) == 0), btn_l, ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
        check($sformatf("random_cycle%0d", c), 16'(dut_out()), 16'(model_out()));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
